// File: rtl/muldiv_unit_pkg.sv
// Shared types for the iterative RV32M multiply/divide unit: funct3 op
// encodings, FSM states and op-class helpers.
package muldiv_unit_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 6;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2,
    MD_DONE = 2'd3
  } md_state_e;

  function automatic logic op_is_div(input md_op_e op);
    return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
  endfunction

  function automatic logic op_a_signed(input md_op_e op);
    return op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
  endfunction

  function automatic logic op_b_signed(input md_op_e op);
    return op inside {MD_MUL, MD_MULH, MD_DIV, MD_REM};
  endfunction

endpackage

// File: rtl/muldiv_unit_negate.sv
// Conditional two's-complement, shared between operand magnitude
// conversion on accept and result sign correction in FIX.
module md_negate
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned W = 2 * XLEN
) (
  input  logic         neg_i,
  input  logic [W-1:0] in_i,
  output logic [W-1:0] y_c_o
);

  assign y_c_o = neg_i ? (~in_i + W'(1)) : in_i;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide responder: one bit per cycle shift-add
// multiply and restoring divide, with RISC-V div-by-zero/overflow results.
module muldiv_unit
  import muldiv_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      md_op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] res,
  output logic            div_zero
);

  localparam int unsigned PW = 2 * XLEN;

  md_state_e         state_q, state_d;
  md_op_e            op_q, op_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [XLEN:0]     rem_q, rem_d;
  logic [XLEN-1:0]   dvs_q, dvs_d;
  logic              sa_q, sa_d, sb_q, sb_d;
  logic              dz_q, dz_d;
  logic              busy_q, busy_d, done_q, done_d, divz_q, divz_d;
  logic [XLEN-1:0]   res_q, res_d;

  md_op_e            op_in;
  logic              accept, in_fix, sa_in, sb_in, is_div_in, b_zero, ovf;
  logic              n0_neg, n1_neg;
  logic [PW-1:0]     n0_in, n0_y;
  logic [XLEN-1:0]   n1_in, n1_y;
  logic [XLEN:0]     mul_sum;
  logic [XLEN+1:0]   div_shl;
  logic              qbit;

  // Operand/quotient/product negation; operands on accept, results in FIX
  md_negate #(.W(PW))   u_neg_wide (.neg_i(n0_neg), .in_i(n0_in), .y_c_o(n0_y));
  md_negate #(.W(XLEN)) u_neg_narrow (.neg_i(n1_neg), .in_i(n1_in), .y_c_o(n1_y));

  always_comb begin
    op_in     = md_op_e'(md_op);
    accept    = start && !kill && (state_q == MD_IDLE || state_q == MD_DONE);
    in_fix    = (state_q == MD_FIX);
    sa_in     = op_a_signed(op_in) && a[XLEN-1];
    sb_in     = op_b_signed(op_in) && b[XLEN-1];
    is_div_in = op_is_div(op_in);
    b_zero    = (b == {XLEN{1'b0}});
    ovf       = (op_in == MD_DIV || op_in == MD_REM) &&
                (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == {XLEN{1'b1}});

    // Product and quotient share the sign rule: negate when signs differ
    n0_neg = in_fix ? (sa_q ^ sb_q) : sa_in;
    n0_in  = in_fix ? (op_is_div(op_q) ? {{XLEN{1'b0}}, acc_q[XLEN-1:0]} : acc_q)
                    : {{XLEN{1'b0}}, a};
    n1_neg = in_fix ? sa_q : sb_in;
    n1_in  = in_fix ? rem_q[XLEN-1:0] : b;

    mul_sum = {1'b0, acc_q[PW-1:XLEN]} + (acc_q[0] ? {1'b0, dvs_q} : {(XLEN+1){1'b0}});
    div_shl = {rem_q, acc_q[XLEN-1]};
    qbit    = (div_shl >= {2'b00, dvs_q});
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    dz_d    = dz_q;
    res_d   = res_q;
    divz_d  = divz_q;

    case (state_q)
      MD_RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (op_is_div(op_q)) begin
          rem_d = (XLEN+1)'(qbit ? (div_shl - {2'b00, dvs_q}) : div_shl);
          acc_d = {acc_q[PW-1:XLEN], acc_q[XLEN-2:0], qbit};
        end else begin
          acc_d = {mul_sum, acc_q[XLEN-1:1]};
        end
        if (cnt_q == CNT_W'(XLEN - 1)) state_d = MD_FIX;
      end
      MD_FIX: begin
        state_d = MD_DONE;
        divz_d  = dz_q;
        case (op_q)
          MD_MUL, MD_DIV, MD_DIVU:     res_d = n0_y[XLEN-1:0];
          MD_MULH, MD_MULHSU, MD_MULHU: res_d = n0_y[PW-1:XLEN];
          default:                     res_d = n1_y;
        endcase
      end
      MD_DONE:  state_d = MD_IDLE;
      default:  state_d = MD_IDLE;
    endcase

    if (accept) begin
      op_d  = op_in;
      cnt_d = '0;
      dz_d  = is_div_in && b_zero;
      // Special results are final values: clear signs so FIX passes them through
      if (is_div_in && b_zero) begin
        acc_d   = {{XLEN{1'b0}}, {XLEN{1'b1}}};
        rem_d   = {1'b0, a};
        sa_d    = 1'b0;
        sb_d    = 1'b0;
        state_d = MD_FIX;
      end else if (ovf) begin
        acc_d   = {{XLEN{1'b0}}, a};
        rem_d   = '0;
        sa_d    = 1'b0;
        sb_d    = 1'b0;
        state_d = MD_FIX;
      end else begin
        acc_d   = {{XLEN{1'b0}}, n0_y[XLEN-1:0]};
        dvs_d   = n1_y;
        rem_d   = '0;
        sa_d    = sa_in;
        sb_d    = sb_in;
        state_d = MD_RUN;
      end
    end

    if (kill) begin
      state_d = MD_IDLE;
      res_d   = res_q;
      divz_d  = divz_q;
    end

    busy_d = (state_d == MD_RUN) || (state_d == MD_FIX);
    done_d = (state_d == MD_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MD_IDLE;
      op_q    <= MD_MUL;
      cnt_q   <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
      divz_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      res_q   <= res_d;
      divz_q  <= divz_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign res      = res_q;
  assign div_zero = divz_q;

endmodule
